// File: rtl/acq_sdram_writer.sv
// Acquisition frame writer: buffers ADC samples in a FIFO and hands them to the
// SDRAM controller as cache loads followed by WRITE commands, one burst at a time.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no frame; waits for i_start
// ST_FILL  | waits until the FIFO holds a full chunk
// ST_LOAD  | pops chunk words into the controller write cache
// ST_ISSUE | waits for controller idle, then issues the WRITE
// ST_GAP   | one cycle for the controller to raise busy
// ST_DRAIN | waits for the WRITE to finish, then advances or ends the frame
module acq_sdram_writer #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 256,
    parameter int FIFO_AW    = 9
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_frame_len,
    input  logic                  i_sample_valid,
    input  logic [DATA_WIDTH-1:0] i_sample,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow,
    output logic [1:0]            o_cmd,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [ADDR_WIDTH-1:0] o_count,
    output logic                  o_wr_cache,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_sdram_busy
);

    localparam int                    DEPTH    = 1 << FIFO_AW;
    localparam logic [ADDR_WIDTH-1:0] BURST    = ADDR_WIDTH'(BURST_LEN);
    localparam logic [FIFO_AW:0]      FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_LOAD,
        ST_ISSUE,
        ST_GAP,
        ST_DRAIN
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr;
    logic [FIFO_AW-1:0]    rd_ptr;
    logic [FIFO_AW:0]      fifo_cnt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] frame_len;
    logic [ADDR_WIDTH-1:0] remaining;
    logic [ADDR_WIDTH-1:0] accepted;
    logic [ADDR_WIDTH-1:0] load_left;
    logic [ADDR_WIDTH-1:0] chunk;
    logic                  fifo_full;
    logic                  want_push;
    logic                  pop;
    logic                  push;
    logic                  drop;

    assign chunk     = (remaining > BURST) ? BURST : remaining;
    assign fifo_full = (fifo_cnt == FULL_CNT);
    assign want_push = o_busy && (accepted < frame_len) && i_sample_valid;
    assign pop       = (state == ST_LOAD);
    // a pop in the same cycle frees a slot, so a full FIFO can still accept
    assign push      = want_push && (!fifo_full || pop);
    assign drop      = want_push && fifo_full && !pop;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_sample;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            cur_addr   <= '0;
            frame_len  <= '0;
            remaining  <= '0;
            accepted   <= '0;
            load_left  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_overflow <= 1'b0;
            o_cmd      <= 2'b00;
            o_addr     <= '0;
            o_count    <= '0;
            o_wr_cache <= 1'b0;
            o_data     <= '0;
        end else begin
            o_done     <= 1'b0;
            o_cmd      <= 2'b00;
            o_wr_cache <= 1'b0;

            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                accepted <= accepted + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (drop) begin
                o_overflow <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        o_overflow <= 1'b0;
                        if (i_frame_len != '0) begin
                            cur_addr  <= i_base_addr;
                            frame_len <= i_frame_len;
                            remaining <= i_frame_len;
                            accepted  <= '0;
                            o_busy    <= 1'b1;
                            state     <= ST_FILL;
                        end else begin
                            o_done <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (ADDR_WIDTH'(fifo_cnt) >= chunk) begin
                        load_left <= chunk;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    o_wr_cache <= 1'b1;
                    o_data     <= mem[rd_ptr];
                    load_left  <= load_left - 1'b1;
                    if (load_left == 1) begin
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!i_sdram_busy) begin
                        o_cmd   <= 2'b01;
                        o_addr  <= cur_addr;
                        o_count <= chunk;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!i_sdram_busy) begin
                        cur_addr  <= cur_addr + chunk;
                        remaining <= remaining - chunk;
                        if (remaining == chunk) begin
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            state <= ST_FILL;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acq_sdram_writer.sv
// Bench for acq_sdram_writer: random sample streams and controller busy times,
// checked against a burst-list and data-order model of the frame.
module tb_acq_sdram_writer;

    localparam int AW  = 24;
    localparam int DW  = 16;
    localparam int BL  = 4;
    localparam int FAW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] frame_len = '0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample = '0;
    logic          sdram_busy = 1'b0;
    logic          o_busy, o_done, o_overflow, o_wr_cache;
    logic [1:0]    o_cmd;
    logic [AW-1:0] o_addr, o_count;
    logic [DW-1:0] o_data;

    acq_sdram_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .FIFO_AW(FAW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
        .i_frame_len(frame_len), .i_sample_valid(sample_valid), .i_sample(sample),
        .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow), .o_cmd(o_cmd),
        .o_addr(o_addr), .o_count(o_count), .o_wr_cache(o_wr_cache), .o_data(o_data),
        .i_sdram_busy(sdram_busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0]   cache_q[$];
    logic [2*AW-1:0] cmd_q[$];
    logic [2*AW-1:0] exp_cmd[$];
    logic [DW-1:0]   drv_q[$];
    int   done_cnt = 0;
    int   bad_cmd = 0;
    bit   drv_on = 0;
    int   drv_pct = 100;
    logic [DW-1:0] drv_val = 16'd1;
    int   busy_cycles = 0;
    int   busy_left = 0;
    bit   hold_busy = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   first_wr_cyc = -1;

    always @(posedge clk) cyc++;

    // Monitor plus controller model: busy for busy_cycles after each WRITE.
    always @(negedge clk) begin
        if (o_wr_cache) cache_q.push_back(o_data);
        if (o_wr_cache && first_wr_cyc < 0) first_wr_cyc = cyc;
        if (o_cmd == 2'b01) cmd_q.push_back({o_addr, o_count});
        if (o_cmd[1]) bad_cmd++;
        if (o_done) done_cnt++;
        if (o_cmd == 2'b01) busy_left = busy_cycles;
        sdram_busy = hold_busy || (busy_left > 0);
        if (busy_left > 0) busy_left--;
    end

    // Sample source: every driven sample is recorded in order.
    always @(posedge clk) begin
        #2;
        if (drv_on && int'($urandom_range(99)) < drv_pct) begin
            sample_valid = 1'b1;
            sample = drv_val;
            drv_q.push_back(drv_val);
            drv_val++;
        end else begin
            sample_valid = 1'b0;
        end
    end

    // Expected burst list: consecutive chunks of at most BL words, address wrapping.
    function automatic void build_expect(input logic [AW-1:0] b, input int l);
        exp_cmd.delete();
        for (int off = 0; off < l; off += BL) begin
            int c;
            c = (l - off < BL) ? (l - off) : BL;
            exp_cmd.push_back({AW'(b + AW'(off)), AW'(c)});
        end
    endfunction

    task automatic start_frame(input logic [AW-1:0] b, input logic [AW-1:0] l);
        @(negedge clk);
        cache_q.delete();
        cmd_q.delete();
        drv_q.delete();
        done_cnt = 0;
        first_wr_cyc = -1;
        base_addr = b;
        frame_len = l;
        start = 1'b1;
        drv_on = 1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic run_frame(input string name, input logic [AW-1:0] b, input int l,
                             input int pct, input int bcy, input int poke, output int lat);
        int n;
        logic [DW-1:0] want;
        busy_cycles = bcy;
        drv_pct = pct;
        start_frame(b, AW'(l));
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            n++;
            if (n == poke) begin
                base_addr = b ^ 24'h000800;
                frame_len = 24'd3;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        drv_on = 0;
        lat = first_wr_cyc - start_cyc;
        build_expect(b, l);
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt);
        end
        vectors++;
        if (cmd_q.size() !== exp_cmd.size()) begin
            miscompares++;
            $display("FAIL %s write_count: got %0d want %0d", name, cmd_q.size(), exp_cmd.size());
        end
        for (int i = 0; i < exp_cmd.size() && i < cmd_q.size(); i++) begin
            vectors++;
            if (cmd_q[i] !== exp_cmd[i]) begin
                miscompares++;
                $display("FAIL %s write[%0d] addr/count: got %h/%0d want %h/%0d", name, i,
                         cmd_q[i][2*AW-1:AW], cmd_q[i][AW-1:0], exp_cmd[i][2*AW-1:AW], exp_cmd[i][AW-1:0]);
            end
        end
        vectors++;
        if (cache_q.size() !== l) begin
            miscompares++;
            $display("FAIL %s cache_words: got %0d want %0d", name, cache_q.size(), l);
        end
        for (int i = 0; i < l && i < cache_q.size(); i++) begin
            want = (i < drv_q.size()) ? drv_q[i] : 'x;
            vectors++;
            if (cache_q[i] !== want) begin
                miscompares++;
                $display("FAIL %s cache[%0d]: got %h want %h", name, i, cache_q[i], want);
            end
        end
        vectors++;
        if ({o_overflow, o_busy} !== 2'b00 || bad_cmd !== 0) begin
            miscompares++;
            $display("FAIL %s end_state ovf/busy/badcmd: got %b/%b/%0d want 0/0/0", name, o_overflow, o_busy, bad_cmd);
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({o_busy, o_done, o_overflow, o_cmd, o_addr, o_count, o_wr_cache, o_data} !== '0) begin
            miscompares++;
            $display("FAIL reset outputs: got busy=%b done=%b ovf=%b cmd=%b addr=%h cnt=%h wr=%b data=%h want all 0",
                     o_busy, o_done, o_overflow, o_cmd, o_addr, o_count, o_wr_cache, o_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        drv_val = 16'd1;
        run_frame("basic", 24'h000100, 10, 100, 3, 0, lat);
        vectors++;
        if (lat !== 6) begin
            miscompares++;
            $display("FAIL basic first_wr_latency: got %0d want 6 cycles after start", lat);
        end
        for (int i = 0; i < 10 && i < cache_q.size(); i++) begin
            vectors++;
            if (cache_q[i] !== DW'(i + 1)) begin
                miscompares++;
                $display("FAIL basic word[%0d]: got %0d want %0d", i, cache_q[i], i + 1);
            end
        end
    endtask

    task automatic test_zero_len();
        start_frame(24'h000055, 24'd0);
        vectors++;
        if ({o_done, o_busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL zero_len done/busy: got %b/%b want 1/0", o_done, o_busy);
        end
        @(negedge clk);
        vectors++;
        if (o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len done_width: got %b want 0", o_done);
        end
        repeat (5) @(negedge clk);
        drv_on = 0;
        vectors++;
        if (cmd_q.size() !== 0 || cache_q.size() !== 0 || o_busy !== 1'b0 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL zero_len activity: got cmds=%0d words=%0d busy=%b dones=%0d want 0/0/0/1",
                     cmd_q.size(), cache_q.size(), o_busy, done_cnt);
        end
    endtask

    task automatic test_overflow();
        int n;
        hold_busy = 1;
        busy_cycles = 2;
        drv_pct = 100;
        drv_val = 16'd1;
        start_frame(24'h002000, 24'd16);
        repeat (40) @(negedge clk);
        vectors++;
        if ({o_overflow, o_busy} !== 2'b11 || cmd_q.size() !== 0) begin
            miscompares++;
            $display("FAIL overflow while_held ovf/busy/cmds: got %b/%b/%0d want 1/1/0", o_overflow, o_busy, cmd_q.size());
        end
        hold_busy = 0;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        drv_on = 0;
        build_expect(24'h002000, 16);
        vectors++;
        if (done_cnt !== 1 || cmd_q.size() !== exp_cmd.size() || cache_q.size() !== 16) begin
            miscompares++;
            $display("FAIL overflow completion dones/cmds/words: got %0d/%0d/%0d want 1/%0d/16",
                     done_cnt, cmd_q.size(), cache_q.size(), exp_cmd.size());
        end
        for (int i = 0; i < exp_cmd.size() && i < cmd_q.size(); i++) begin
            vectors++;
            if (cmd_q[i] !== exp_cmd[i]) begin
                miscompares++;
                $display("FAIL overflow write[%0d]: got %h want %h", i, cmd_q[i], exp_cmd[i]);
            end
        end
        for (int i = 0; i < 12 && i < cache_q.size(); i++) begin
            vectors++;
            if (cache_q[i] !== DW'(i + 1)) begin
                miscompares++;
                $display("FAIL overflow word[%0d]: got %0d want %0d", i, cache_q[i], i + 1);
            end
        end
        for (int i = 12; i < cache_q.size(); i++) begin
            vectors++;
            if (cache_q[i] <= ((i == 12) ? DW'(13) : cache_q[i-1])) begin
                miscompares++;
                $display("FAIL overflow late_word[%0d]: got %0d want above %0d", i, cache_q[i],
                         (i == 12) ? 13 : int'(cache_q[i-1]));
            end
        end
        vectors++;
        if (o_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow sticky: got %b want 1", o_overflow);
        end
        start_frame(24'h000000, 24'd0);
        drv_on = 0;
        vectors++;
        if (o_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow clear_on_start: got %b want 0", o_overflow);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wrap();
        int lat;
        drv_val = 16'h0A00;
        run_frame("wrap", 24'hFFFFFE, 6, 100, 1, 0, lat);
    endtask

    task automatic test_start_ignored();
        int lat;
        drv_val = 16'h0B00;
        run_frame("ignored_start", 24'h000400, 8, 100, 2, 3, lat);
    endtask

    task automatic test_reset_mid();
        int n;
        int lat;
        busy_cycles = 0;
        drv_pct = 100;
        drv_val = 16'h0C00;
        start_frame(24'h000200, 24'd8);
        n = 0;
        while (!o_wr_cache && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (o_wr_cache !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid reach_load: got wr_cache=%b want 1", o_wr_cache);
        end
        #2 rst_n = 1'b0;
        drv_on = 0;
        #1;
        vectors++;
        if ({o_busy, o_done, o_overflow, o_cmd, o_addr, o_count, o_wr_cache, o_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid async_clear: got busy=%b cmd=%b wr=%b data=%h want all 0",
                     o_busy, o_cmd, o_wr_cache, o_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if (done_cnt !== 0 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid aborted_frame dones/busy: got %0d/%b want 0/0", done_cnt, o_busy);
        end
        drv_val = 16'h0050;
        run_frame("after_reset", 24'h000300, 5, 100, 1, 0, lat);
    endtask

    task automatic test_random();
        int lat;
        for (int k = 0; k < 8; k++) begin
            drv_val = DW'($urandom);
            run_frame("random", AW'($urandom), int'($urandom_range(20, 1)), 20,
                      int'($urandom_range(2, 0)), 0, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_overflow();
        test_wrap();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/acq_sdram_writer.md
Name: acq_sdram_writer

Overview:
Upstream feeder of the SDRAM controller on the acquisition path. It captures one frame of ADC echo samples into an internal FIFO and splits the frame into bursts. For each burst it loads the words into the controller's write cache, then issues a WRITE command with the burst address and count. It absorbs ADC-rate data while the controller is busy, and flags any sample it loses.

Parameters:
ADDR_WIDTH, 24, word-address width (bank+row+col), same as the controller i_addr/i_count.
DATA_WIDTH, 16, sample/word width.
BURST_LEN, 256, maximum words per WRITE command.
FIFO_AW, 9, log2 of FIFO depth (512 words); must satisfy 2^FIFO_AW >= BURST_LEN.

Ports:
i_clk  in  1  system clock.
i_rst_n  in  1  asynchronous active-low reset.
i_start  in  1  one-cycle pulse; starts a frame; ignored while o_busy=1.
i_base_addr  in  ADDR_WIDTH  first SDRAM word address, sampled on i_start.
i_frame_len  in  ADDR_WIDTH  number of samples in the frame, sampled on i_start.
i_sample_valid  in  1  sample strobe.
i_sample  in  DATA_WIDTH  ADC sample.
o_busy  out  1  frame in progress.
o_done  out  1  one-cycle pulse when the last burst has completed.
o_overflow  out  1  sticky; a sample was dropped because the FIFO was full.
o_cmd  out  2  controller command: 00=NOP, 01=WRITE; 10/11 never driven.
o_addr  out  ADDR_WIDTH  burst start address; valid while o_cmd=01.
o_count  out  ADDR_WIDTH  burst word count; valid while o_cmd=01.
o_wr_cache  out  1  push strobe into the controller write cache.
o_data  out  DATA_WIDTH  cache word; valid when o_wr_cache=1.
i_sdram_busy  in  1  controller busy.

Behaviour:
- Clock and reset: i_clk is the single clock. i_rst_n is asynchronous and active-low.
- Reset values: every output is 0; FSM in IDLE; FIFO empty; all counters 0.
- Reset mid-operation: abort immediately, flush the FIFO, discard the partial frame, produce no o_done.
- All outputs are registered.
- Accepting samples:
  - A sample is accepted when o_busy=1, fewer than frame_len samples have been accepted, i_sample_valid=1 and the FIFO is not full.
  - If the FIFO is full, the sample is dropped, o_overflow is set, and the accepted count does not advance. The frame still ends only after frame_len samples are accepted.
  - o_overflow is cleared only by the next accepted i_start.
  - Samples arriving beyond frame_len, or while idle, are ignored.
- Burst size: chunk = min(BURST_LEN, remaining), where remaining = frame_len minus words already loaded.
- FSM states and transitions:
  - IDLE: on i_start with i_frame_len != 0, latch address and length, set o_busy=1, go to FILL. On i_start with i_frame_len == 0, pulse o_done and stay IDLE.
  - FILL: when FIFO count >= chunk, go to LOAD.
  - LOAD: assert o_wr_cache for exactly chunk consecutive cycles, popping one word per cycle, with o_data = popped word. Sample writes into the FIFO continue in parallel. Then go to ISSUE.
  - ISSUE: wait for i_sdram_busy=0, then drive o_cmd=01, o_addr=current address, o_count=chunk for exactly one cycle. Go to GAP.
  - GAP: one cycle, which lets the controller raise busy. Go to DRAIN.
  - DRAIN: wait for i_sdram_busy=0. Then address += chunk (mod 2^ADDR_WIDTH, wraps to 0) and remaining -= chunk. If remaining == 0, pulse o_done, clear o_busy and go to IDLE; otherwise go to FILL.
- Latency: first o_wr_cache occurs 2 cycles after the cycle in which the FIFO count reaches chunk (one cycle to enter LOAD, one registered output).
- Simultaneous push and pop on the FIFO: both occur and the count is unchanged. When full, a simultaneous pop makes room, so the push is accepted.
- i_start while o_busy=1 is ignored and does not alter the latched parameters.

Test Plan:
- BURST_LEN=4, FIFO_AW=3, base=0x000100, len=10, continuous samples 1..10, controller busy 3 cycles per cmd -> three WRITEs: (0x100,4), (0x104,4), (0x108,2); cache words 1..10 in order; exactly one o_done pulse; o_overflow=0.
- len=0 start -> o_done pulses the cycle after i_start; o_cmd stays 00; o_busy stays 0.
- Hold i_sdram_busy=1 for 40 cycles with continuous samples, FIFO depth 8 -> the 9th pending sample is dropped and o_overflow=1; the frame still completes after len accepted samples; o_overflow clears on the next i_start.
- base=0xFFFFFE, len=4, BURST_LEN=2 -> WRITEs at 0xFFFFFE and then 0x000000.
- Assert i_rst_n=0 during LOAD -> all outputs 0 within the same cycle (async); a new frame after reset writes from its own base with correct data.
- i_start pulsed again mid-frame with different base/len -> ignored; the original frame's addresses and counts are unchanged.
